// File: rtl/mm_store_buffer.sv
// mm_store_buffer: formats sb/sh/sw/sd into 8-lane write data and byte enables,
// queues them in a small in-order FIFO, drains them to the data cache write port
// over req/ack, and flags loads whose doubleword overlaps any queued store.
module mm_store_buffer #(
    parameter int ADDRESS_WIDTH          = 64,
    parameter int REGISTER_WIDTH         = 64,
    parameter int INSTRUCTION_NAME_WIDTH = 96,
    parameter int DEPTH                  = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_enable,
    input  logic [INSTRUCTION_NAME_WIDTH-1:0] in_opcode_name,
    input  logic [ADDRESS_WIDTH-1:0]          in_alu_result,
    input  logic [REGISTER_WIDTH-1:0]         in_rs2_value,
    output logic                              out_ready,
    output logic                              out_misaligned,
    input  logic                              in_load_check,
    input  logic [ADDRESS_WIDTH-1:0]          in_load_addr,
    output logic                              out_load_hazard,
    output logic                              out_wr_req,
    output logic [ADDRESS_WIDTH-1:0]          out_wr_addr,
    output logic [63:0]                       out_wr_data,
    output logic [7:0]                        out_wr_be,
    input  logic                              in_wr_ack,
    output logic [$clog2(DEPTH+1)-1:0]        out_count,
    output logic                              out_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TAG_W = ADDRESS_WIDTH - 3;

    // Opcode names are ASCII, right-justified and zero-padded on the left.
    localparam logic [INSTRUCTION_NAME_WIDTH-1:0] NAME_SB = INSTRUCTION_NAME_WIDTH'(16'h7362);
    localparam logic [INSTRUCTION_NAME_WIDTH-1:0] NAME_SH = INSTRUCTION_NAME_WIDTH'(16'h7368);
    localparam logic [INSTRUCTION_NAME_WIDTH-1:0] NAME_SW = INSTRUCTION_NAME_WIDTH'(16'h7377);
    localparam logic [INSTRUCTION_NAME_WIDTH-1:0] NAME_SD = INSTRUCTION_NAME_WIDTH'(16'h7364);

    logic [TAG_W-1:0] tag_q  [DEPTH];
    logic [63:0]      data_q [DEPTH];
    logic [7:0]       be_q   [DEPTH];
    logic [DEPTH-1:0] valid_q;

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_next;
    logic             empty_q;
    logic             misaligned_q;

    logic        is_store;
    logic        aligned;
    logic [7:0]  fmt_be;
    logic [63:0] fmt_data;
    logic        full;
    logic        enq;
    logic        deq;
    logic        bad_store;
    logic        tag_hit;
    logic        unused_load_offset;

    // Decode the opcode name and position the store data onto its byte lanes.
    always_comb begin
        logic [2:0] off;
        logic [5:0] shamt;
        off      = in_alu_result[2:0];
        shamt    = {off, 3'b000};
        is_store = 1'b1;
        aligned  = 1'b1;
        fmt_be   = 8'h00;
        fmt_data = 64'h0;
        if (in_opcode_name == NAME_SB) begin
            fmt_be   = 8'h01 << off;
            fmt_data = 64'(in_rs2_value[7:0]) << shamt;
        end else if (in_opcode_name == NAME_SH) begin
            aligned  = (off[0] == 1'b0);
            fmt_be   = 8'h03 << off;
            fmt_data = 64'(in_rs2_value[15:0]) << shamt;
        end else if (in_opcode_name == NAME_SW) begin
            aligned  = (off[1:0] == 2'b00);
            fmt_be   = 8'h0F << off;
            fmt_data = 64'(in_rs2_value[31:0]) << shamt;
        end else if (in_opcode_name == NAME_SD) begin
            aligned  = (off == 3'b000);
            fmt_be   = 8'hFF;
            fmt_data = in_rs2_value[63:0];
        end else begin
            is_store = 1'b0;
        end
    end

    // Ready looks only at the registered occupancy so an ack in flight never
    // opens a slot combinationally.
    always_comb begin
        full       = (count_q == CNT_W'(DEPTH));
        out_ready  = !is_store || !full;
        enq        = in_enable && is_store && out_ready && aligned;
        bad_store  = in_enable && is_store && out_ready && !aligned;
        deq        = !empty_q && in_wr_ack;
        count_next = count_q;
        if (enq && !deq) begin
            count_next = count_q + CNT_W'(1);
        end else if (!enq && deq) begin
            count_next = count_q - CNT_W'(1);
        end
    end

    // Pointer, occupancy, valid-bit and misaligned-pulse bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            empty_q      <= 1'b1;
            valid_q      <= '0;
            misaligned_q <= 1'b0;
        end else begin
            count_q      <= count_next;
            empty_q      <= (count_next == '0);
            misaligned_q <= bad_store;
            if (deq) begin
                head_q          <= head_q + PTR_W'(1);
                valid_q[head_q] <= 1'b0;
            end
            if (enq) begin
                tail_q          <= tail_q + PTR_W'(1);
                valid_q[tail_q] <= 1'b1;
            end
        end
    end

    // Entry payload; only meaningful while the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (enq) begin
            tag_q[tail_q]  <= in_alu_result[ADDRESS_WIDTH-1:3];
            data_q[tail_q] <= fmt_data;
            be_q[tail_q]   <= fmt_be;
        end
    end

    // Doubleword-granular overlap check against every valid entry, head included.
    always_comb begin
        tag_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == in_load_addr[ADDRESS_WIDTH-1:3])) begin
                tag_hit = 1'b1;
            end
        end
        out_load_hazard = in_load_check && tag_hit;
    end

    // Head entry presented to the cache; forced to zero while nothing is queued.
    always_comb begin
        out_wr_req  = !empty_q;
        out_wr_addr = '0;
        out_wr_data = '0;
        out_wr_be   = '0;
        if (!empty_q) begin
            out_wr_addr = {tag_q[head_q], 3'b000};
            out_wr_data = data_q[head_q];
            out_wr_be   = be_q[head_q];
        end
    end

    assign out_count          = count_q;
    assign out_empty          = empty_q;
    assign out_misaligned     = misaligned_q;
    assign unused_load_offset = ^in_load_addr[2:0];

endmodule

// File: tb/tb_mm_store_buffer.sv
// Directed bench for mm_store_buffer: formatting, misalignment, full/ack
// interplay, FIFO ordering across wrap, load hazard and async reset.
module tb_mm_store_buffer;

    localparam logic [95:0] OP_SB = 96'h7362;
    localparam logic [95:0] OP_SH = 96'h7368;
    localparam logic [95:0] OP_SW = 96'h7377;
    localparam logic [95:0] OP_SD = 96'h7364;
    localparam logic [95:0] OP_LD = 96'h6c64;

    logic        clk;
    logic        reset;
    logic        in_enable;
    logic [95:0] in_opcode_name;
    logic [63:0] in_alu_result;
    logic [63:0] in_rs2_value;
    logic        out_ready;
    logic        out_misaligned;
    logic        in_load_check;
    logic [63:0] in_load_addr;
    logic        out_load_hazard;
    logic        out_wr_req;
    logic [63:0] out_wr_addr;
    logic [63:0] out_wr_data;
    logic [7:0]  out_wr_be;
    logic        in_wr_ack;
    logic [2:0]  out_count;
    logic        out_empty;

    int checks = 0;
    int errors = 0;

    mm_store_buffer #(
        .ADDRESS_WIDTH(64), .REGISTER_WIDTH(64),
        .INSTRUCTION_NAME_WIDTH(96), .DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset),
        .in_enable(in_enable), .in_opcode_name(in_opcode_name),
        .in_alu_result(in_alu_result), .in_rs2_value(in_rs2_value),
        .out_ready(out_ready), .out_misaligned(out_misaligned),
        .in_load_check(in_load_check), .in_load_addr(in_load_addr),
        .out_load_hazard(out_load_hazard),
        .out_wr_req(out_wr_req), .out_wr_addr(out_wr_addr),
        .out_wr_data(out_wr_data), .out_wr_be(out_wr_be),
        .in_wr_ack(in_wr_ack), .out_count(out_count), .out_empty(out_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [95:0] op, input logic [63:0] addr, input logic [63:0] data);
        in_enable      = 1'b1;
        in_opcode_name = op;
        in_alu_result  = addr;
        in_rs2_value   = data;
    endtask

    task automatic push(input logic [95:0] op, input logic [63:0] addr, input logic [63:0] data);
        drive(op, addr, data);
        tick();
        in_enable = 1'b0;
    endtask

    initial begin
        reset = 1'b0; in_enable = 1'b0; in_opcode_name = '0; in_alu_result = '0;
        in_rs2_value = '0; in_load_check = 1'b0; in_load_addr = '0; in_wr_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 64'(out_count), 64'd0);
        check("rst_empty", 64'(out_empty), 64'd1);
        check("rst_req", 64'(out_wr_req), 64'd0);
        check("rst_mis", 64'(out_misaligned), 64'd0);
        check("rst_be", 64'(out_wr_be), 64'd0);
        reset = 1'b1;
        tick();

        // sb at offset 3, then ack one cycle later
        push(OP_SB, 64'h1003, 64'hAB);
        check("sb_req", 64'(out_wr_req), 64'd1);
        check("sb_addr", out_wr_addr, 64'h1000);
        check("sb_be", 64'(out_wr_be), 64'h08);
        check("sb_data", out_wr_data, 64'h00000000AB000000);
        check("sb_count", 64'(out_count), 64'd1);
        in_wr_ack = 1'b1;
        tick();
        in_wr_ack = 1'b0;
        check("sb_drained_count", 64'(out_count), 64'd0);
        check("sb_drained_empty", 64'(out_empty), 64'd1);
        check("sb_drained_req", 64'(out_wr_req), 64'd0);

        // sw at offset 4 with zero-wait ack
        push(OP_SW, 64'h1004, 64'hDEADBEEF);
        in_wr_ack = 1'b1;
        check("sw_addr", out_wr_addr, 64'h1000);
        check("sw_be", 64'(out_wr_be), 64'hF0);
        check("sw_data", out_wr_data, 64'hDEADBEEF00000000);
        tick();
        in_wr_ack = 1'b0;
        check("sw_count", 64'(out_count), 64'd0);

        // sh at offset 2
        push(OP_SH, 64'h1002, 64'hFFFF1234);
        in_wr_ack = 1'b1;
        check("sh_be", 64'(out_wr_be), 64'h0C);
        check("sh_data", out_wr_data, 64'h0000000012340000);
        tick();
        in_wr_ack = 1'b0;

        // misaligned sh is dropped with a one-cycle pulse
        drive(OP_SH, 64'h2001, 64'h5555);
        check("mis_ready", 64'(out_ready), 64'd1);
        tick();
        in_enable = 1'b0;
        check("mis_pulse", 64'(out_misaligned), 64'd1);
        check("mis_count", 64'(out_count), 64'd0);
        check("mis_req", 64'(out_wr_req), 64'd0);
        tick();
        check("mis_pulse_end", 64'(out_misaligned), 64'd0);

        // non-store is accepted but not queued
        drive(OP_LD, 64'h2000, 64'h1);
        check("ld_ready", 64'(out_ready), 64'd1);
        tick();
        in_enable = 1'b0;
        check("ld_count", 64'(out_count), 64'd0);
        check("ld_mis", 64'(out_misaligned), 64'd0);

        // five back-to-back sd with ack low
        for (int i = 0; i < 4; i++) begin
            drive(OP_SD, 64'(256 * (i + 1)), 64'(i + 1));
            check("fill_ready", 64'(out_ready), 64'd1);
            tick();
            check("fill_count", 64'(out_count), 64'(i + 1));
        end
        drive(OP_SD, 64'h500, 64'd5);
        check("full_ready", 64'(out_ready), 64'd0);
        in_wr_ack = 1'b1;
        check("full_ack_ready", 64'(out_ready), 64'd0);
        tick();
        in_wr_ack = 1'b0;
        check("after_ack_count", 64'(out_count), 64'd3);
        check("after_ack_head", out_wr_data, 64'd2);
        check("fifth_ready", 64'(out_ready), 64'd1);
        tick();
        in_enable = 1'b0;
        check("fifth_count", 64'(out_count), 64'd4);
        in_wr_ack = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            check("wrap_data", out_wr_data, 64'(k));
            check("wrap_addr", out_wr_addr, 64'(256 * k));
            tick();
        end
        in_wr_ack = 1'b0;
        check("wrap_empty", 64'(out_empty), 64'd1);

        // full + ack + store: store rejected
        for (int i = 5; i <= 8; i++) push(OP_SD, 64'(256 * i), 64'(16 * i));
        check("full2_count", 64'(out_count), 64'd4);
        drive(OP_SD, 64'h900, 64'h99);
        in_wr_ack = 1'b1;
        check("full2_ready", 64'(out_ready), 64'd0);
        tick();
        in_enable = 1'b0;
        check("full2_reject_count", 64'(out_count), 64'd3);
        for (int k = 6; k <= 8; k++) begin
            check("full2_order", out_wr_data, 64'(16 * k));
            tick();
        end
        in_wr_ack = 1'b0;
        check("full2_empty", 64'(out_count), 64'd0);

        // count=2 + ack + store: count holds, new entry at tail
        push(OP_SD, 64'hA00, 64'hA);
        push(OP_SD, 64'hB00, 64'hB);
        drive(OP_SD, 64'hC00, 64'hC);
        in_wr_ack = 1'b1;
        check("mid_ready", 64'(out_ready), 64'd1);
        tick();
        in_enable = 1'b0;
        in_wr_ack = 1'b0;
        check("mid_count", 64'(out_count), 64'd2);
        check("mid_head", out_wr_data, 64'hB);
        in_wr_ack = 1'b1;
        tick();
        check("mid_tail", out_wr_data, 64'hC);
        check("mid_tail_addr", out_wr_addr, 64'hC00);
        tick();
        in_wr_ack = 1'b0;
        check("mid_empty", 64'(out_empty), 64'd1);

        // load hazard against a queued sd
        push(OP_SD, 64'h3000, 64'h33);
        in_load_check = 1'b1;
        in_load_addr  = 64'h3006;
        #1 check("haz_hit", 64'(out_load_hazard), 64'd1);
        in_load_addr = 64'h3008;
        #1 check("haz_miss", 64'(out_load_hazard), 64'd0);
        in_load_addr = 64'h3006;
        in_load_check = 1'b0;
        #1 check("haz_nocheck", 64'(out_load_hazard), 64'd0);
        in_load_check = 1'b1;
        in_wr_ack = 1'b1;
        #1 check("haz_acking", 64'(out_load_hazard), 64'd1);
        tick();
        in_wr_ack = 1'b0;
        check("haz_after_ack", 64'(out_load_hazard), 64'd0);
        in_load_check = 1'b0;

        // async reset with three entries queued
        push(OP_SD, 64'hD00, 64'hD);
        push(OP_SD, 64'hE00, 64'hE);
        push(OP_SD, 64'hF00, 64'hF);
        check("pre_rst_count", 64'(out_count), 64'd3);
        #2 reset = 1'b0;
        #1;
        check("async_rst_count", 64'(out_count), 64'd0);
        check("async_rst_req", 64'(out_wr_req), 64'd0);
        check("async_rst_empty", 64'(out_empty), 64'd1);
        check("async_rst_data", out_wr_data, 64'd0);
        tick();
        reset = 1'b1;
        tick();
        push(OP_SD, 64'h4000, 64'h77);
        check("post_rst_count", 64'(out_count), 64'd1);
        check("post_rst_addr", out_wr_addr, 64'h4000);
        check("post_rst_data", out_wr_data, 64'h77);
        check("post_rst_be", 64'(out_wr_be), 64'hFF);
        in_wr_ack = 1'b1;
        tick();
        in_wr_ack = 1'b0;
        check("post_rst_empty", 64'(out_empty), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
